// File: rtl/store_buffer.sv
// Word-store FIFO in front of the data memory with youngest-match store-to-load forwarding.
// Optional store coalescing into the youngest entry is enabled by defining SB_COALESCE_EN.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [31:0]              st_pc,
    output logic                     st_ready,
    input  logic                     ld_req,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hit,
    output logic [31:0]              ld_data,
    output logic                     dm_we,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_wd,
    output logic [31:0]              dm_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] young;
    logic          full;
    logic          coal;
    logic          push;
    logic          unused;

    assign young  = tail - PW'(1);
    assign full   = (count == CW'(DEPTH));
    assign unused = ^{ld_addr[31:AW+2], ld_addr[1:0]};

    // Reset also gates the strobe so discarded stores never reach memory.
    assign dm_we   = (count != '0) && !ld_req && !reset;
    assign dm_addr = mem[head].addr;
    assign dm_wd   = mem[head].data;
    assign dm_pc   = mem[head].pc;

`ifdef SB_COALESCE_EN
    // Merge into the youngest entry unless that entry is leaving this cycle.
    assign coal = st_valid && (count != '0)
                  && (mem[young].addr[AW+1:2] == st_addr[AW+1:2])
                  && !((young == head) && dm_we);
    assign st_ready = !full || coal;
`else
    assign coal     = 1'b0;
    assign st_ready = !full;
`endif

    assign push = st_valid && st_ready && !coal;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (dm_we) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(dm_we);
        end
    end

    // Entry storage carries no reset; validity is defined by head/count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push) begin
                mem[tail] <= '{addr: st_addr, data: st_data, pc: st_pc};
            end else if (coal) begin
                mem[young].data <= st_data;
                mem[young].pc   <= st_pc;
            end
        end
    end

    // Scan oldest to youngest so the last match is the youngest.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count)
                && (mem[head + PW'(i)].addr[AW+1:2] == ld_addr[AW+1:2])) begin
                ld_hit  = 1'b1;
                ld_data = mem[head + PW'(i)].data;
            end
        end
    end

endmodule
